// File: rtl/flow_bus_serializer.sv
// Wide-to-narrow stream serializer: one DATA_NUM-word input beat becomes DATA_NUM
// consecutive narrow output beats, with zero-bubble reload on the last word.
module flow_bus_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_NUM   = 2,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit USE_ENABLE = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    output logic                           up_ready,
    input  logic                           up_valid,
    input  logic [DATA_WIDTH*DATA_NUM-1:0] up_data,
    input  logic                           down_ready,
    output logic                           down_valid,
    output logic [DATA_WIDTH-1:0]          down_data,
    output logic                           down_last
);

    localparam int IDX_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_NUM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                          busy;
    state_t                          busy_nxt;
    logic [IDX_W-1:0]                idx;
    logic [IDX_W-1:0]                idx_nxt;
    logic [IDX_W-1:0]                wsel;
    logic [DATA_WIDTH*DATA_NUM-1:0]  hold;
    logic                            en;
    logic                            load;
    logic                            up_xfer;
    logic                            down_xfer;

    assign en         = USE_ENABLE ? enable : 1'b1;
    assign down_last  = (busy == SEND) && (idx == IDX_LAST);
    assign down_valid = en && (busy == SEND);
    // Ready on the last word lets the next wide word load on the same edge.
    assign up_ready   = en && ((busy == IDLE) || (down_last && down_ready));
    assign up_xfer    = up_valid && up_ready;
    assign down_xfer  = down_valid && down_ready;
    assign wsel       = LSB_FIRST ? idx : (IDX_LAST - idx);

    always_comb begin
        down_data = '0;
        for (int i = 0; i < DATA_NUM; i++) begin
            if (int'(wsel) == i) begin
                down_data = hold[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        busy_nxt = busy;
        idx_nxt  = idx;
        load     = 1'b0;
        if (up_xfer) begin
            load     = 1'b1;
            busy_nxt = SEND;
            idx_nxt  = '0;
        end else if (down_xfer) begin
            if (down_last) begin
                busy_nxt = IDLE;
                idx_nxt  = '0;
            end else begin
                idx_nxt = idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= IDLE;
            idx  <= '0;
        end else begin
            busy <= busy_nxt;
            idx  <= idx_nxt;
        end
    end

    // Data path carries no reset; contents are only visible while down_valid is high.
    always_ff @(posedge clk) begin
        if (load) begin
            hold <= up_data;
        end
    end

endmodule

// File: tb/tb_flow_bus_serializer.sv
// Directed bench for flow_bus_serializer: LSB/MSB-first, back-to-back, backpressure,
// mid-word reset, enable gap and single-word configurations.
module tb_flow_bus_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // A: LSB first, no enable
    logic        a_ur, a_uv = 1'b0, a_dr = 1'b0, a_dv, a_dl;
    logic [31:0] a_ud = '0;
    logic [7:0]  a_dd;
    // B: MSB first
    logic        b_ur, b_uv = 1'b0, b_dr = 1'b0, b_dv, b_dl;
    logic [31:0] b_ud = '0;
    logic [7:0]  b_dd;
    // C: enable effective
    logic        c_en = 1'b1, c_ur, c_uv = 1'b0, c_dr = 1'b0, c_dv, c_dl;
    logic [31:0] c_ud = '0;
    logic [7:0]  c_dd;
    // D: single-word
    logic        d_ur, d_uv = 1'b0, d_dr = 1'b0, d_dv, d_dl;
    logic [7:0]  d_ud = '0;
    logic [7:0]  d_dd;

    flow_bus_serializer #(.DATA_WIDTH(8), .DATA_NUM(4), .LSB_FIRST(1'b1), .USE_ENABLE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .enable(1'b1), .up_ready(a_ur), .up_valid(a_uv), .up_data(a_ud),
        .down_ready(a_dr), .down_valid(a_dv), .down_data(a_dd), .down_last(a_dl));

    flow_bus_serializer #(.DATA_WIDTH(8), .DATA_NUM(4), .LSB_FIRST(1'b0), .USE_ENABLE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .enable(1'b1), .up_ready(b_ur), .up_valid(b_uv), .up_data(b_ud),
        .down_ready(b_dr), .down_valid(b_dv), .down_data(b_dd), .down_last(b_dl));

    flow_bus_serializer #(.DATA_WIDTH(8), .DATA_NUM(4), .LSB_FIRST(1'b1), .USE_ENABLE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .enable(c_en), .up_ready(c_ur), .up_valid(c_uv), .up_data(c_ud),
        .down_ready(c_dr), .down_valid(c_dv), .down_data(c_dd), .down_last(c_dl));

    flow_bus_serializer #(.DATA_WIDTH(8), .DATA_NUM(1), .LSB_FIRST(1'b1), .USE_ENABLE(1'b0)) dut_d (
        .clk(clk), .rst(rst), .enable(1'b1), .up_ready(d_ur), .up_valid(d_uv), .up_data(d_ud),
        .down_ready(d_dr), .down_valid(d_dv), .down_data(d_dd), .down_last(d_dl));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          pat [10] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1};
    logic [7:0]  bexp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int          k;

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_a_dv", 32'(a_dv), 32'd0);
        check("rst_a_dl", 32'(a_dl), 32'd0);
        check("rst_a_ur", 32'(a_ur), 32'd1);
        check("rst_c_ur", 32'(c_ur), 32'd1);
        c_en = 1'b0;
        #1;
        check("idle_c_ur_disabled", 32'(c_ur), 32'd0);
        c_en = 1'b1;

        // Single wide word, LSB first
        a_ud = 32'h44332211; a_uv = 1'b1; a_dr = 1'b1;
        #1;
        check("lsb_load_ur", 32'(a_ur), 32'd1);
        tick();
        a_uv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("lsb_dv", 32'(a_dv), 32'd1);
            check("lsb_dd", 32'(a_dd), 32'((i + 1) * 17));
            check("lsb_dl", 32'(a_dl), 32'(i == 3));
            check("lsb_ur", 32'(a_ur), 32'(i == 3));
            tick();
        end
        #1;
        check("lsb_end_dv", 32'(a_dv), 32'd0);
        check("lsb_end_ur", 32'(a_ur), 32'd1);

        // Two wide words back to back
        a_ud = 32'h44332211; a_uv = 1'b1;
        tick();
        a_ud = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("b2b_dv", 32'(a_dv), 32'd1);
            check("b2b_dd", 32'(a_dd), 32'((i + 1) * 17));
            check("b2b_dl", 32'(a_dl), 32'(i % 4 == 3));
            check("b2b_ur", 32'(a_ur), 32'(i % 4 == 3));
            tick();
            if (i == 3) a_uv = 1'b0;
        end
        #1;
        check("b2b_end_dv", 32'(a_dv), 32'd0);

        // Backpressure on down_ready
        a_ud = 32'h44332211; a_uv = 1'b1; a_dr = 1'b1;
        tick();
        a_uv = 1'b0;
        k = 0;
        for (int j = 0; j < 10 && k < 4; j++) begin
            a_dr = pat[j][0];
            #1;
            check("bp_dv", 32'(a_dv), 32'd1);
            check("bp_dd", 32'(a_dd), 32'((k + 1) * 17));
            check("bp_dl", 32'(a_dl), 32'(k == 3));
            check("bp_ur", 32'(a_ur), 32'((k == 3) && a_dr));
            tick();
            if (pat[j] != 0) k++;
        end
        check("bp_drained", 32'(k), 32'd4);
        a_dr = 1'b1;
        #1;
        check("bp_end_dv", 32'(a_dv), 32'd0);

        // Reset after two of four words
        a_ud = 32'h44332211; a_uv = 1'b1;
        tick();
        a_uv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mrst_dd", 32'(a_dd), 32'((i + 1) * 17));
            if (i < 2) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_dv", 32'(a_dv), 32'd0);
        check("mrst_ur", 32'(a_ur), 32'd1);
        check("mrst_dl", 32'(a_dl), 32'd0);
        a_ud = 32'hDDCCBBAA; a_uv = 1'b1;
        tick();
        a_uv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mrst_new_dd", 32'(a_dd), 32'(8'h99 + (i + 1) * 17));
            check("mrst_new_dl", 32'(a_dl), 32'(i == 3));
            tick();
        end

        // MSB first
        b_ud = 32'hA1B2C3D4; b_uv = 1'b1; b_dr = 1'b1;
        tick();
        b_uv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("msb_dv", 32'(b_dv), 32'd1);
            check("msb_dd", 32'(b_dd), 32'(bexp[i]));
            check("msb_dl", 32'(b_dl), 32'(i == 3));
            tick();
        end
        #1;
        check("msb_end_dv", 32'(b_dv), 32'd0);

        // Enable gap mid-word
        c_ud = 32'h44332211; c_uv = 1'b1; c_dr = 1'b1;
        tick();
        c_uv = 1'b0;
        #1;
        check("en_dd0", 32'(c_dd), 32'h11);
        tick();
        c_en = 1'b0;
        for (int g = 0; g < 3; g++) begin
            #1;
            check("en_gap_dv", 32'(c_dv), 32'd0);
            check("en_gap_ur", 32'(c_ur), 32'd0);
            tick();
        end
        c_en = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            check("en_res_dv", 32'(c_dv), 32'd1);
            check("en_res_dd", 32'(c_dd), 32'((i + 1) * 17));
            check("en_res_dl", 32'(c_dl), 32'(i == 3));
            tick();
        end
        #1;
        check("en_end_dv", 32'(c_dv), 32'd0);

        // Single-word configuration at full rate
        check("one_idle_dl", 32'(d_dl), 32'd0);
        d_ud = 8'h5A; d_uv = 1'b1; d_dr = 1'b1;
        tick();
        d_ud = 8'hC3;
        #1;
        check("one_dv0", 32'(d_dv), 32'd1);
        check("one_dd0", 32'(d_dd), 32'h5A);
        check("one_dl0", 32'(d_dl), 32'd1);
        check("one_ur0", 32'(d_ur), 32'd1);
        tick();
        d_uv = 1'b0;
        #1;
        check("one_dd1", 32'(d_dd), 32'hC3);
        check("one_dl1", 32'(d_dl), 32'd1);
        tick();
        #1;
        check("one_end_dv", 32'(d_dv), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
